// File: rtl/pe_inject_arbiter.sv
// pe_inject_arbiter: packet-atomic round-robin arbiter for the PE NoC injection port with credit flow control
// ports: req_valid/req_data/req_ready per-source flit handshake (20b flits, type in [19:18]);
//        dataout/out_valid registered flit to router; ci credit return; grant owner while locked;
//        credits live count; proto_err/credit_err sticky error flags.
`timescale 1ns/1ps
module pe_inject_arbiter #(
  parameter int NREQ = 4,
  parameter int CREDITS = 7,
  parameter int CW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*20-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              ci,
  output logic [19:0]       dataout,
  output logic              out_valid,
  output logic [NREQ-1:0]   grant,
  output logic [CW-1:0]     credits,
  output logic              proto_err,
  output logic              credit_err
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_n;
  logic [PW-1:0] owner, owner_n, rr_ptr, rr_ptr_n, cand, idx, sel, sel_inc;
  logic send, perr_set;
  logic [19:0] flit;
  logic [1:0] ftype;
  // descending scan so the last hit is the valid source closest after rr_ptr
  always_comb begin
    cand = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = PW'((int'(rr_ptr) + k) % NREQ);
      if (req_valid[idx]) cand = idx;
    end
  end
  assign sel = state == LOCKED ? owner : cand;
  assign sel_inc = int'(sel) == NREQ - 1 ? '0 : sel + 1'b1;
  // with no valid source cand is 0 and req_valid[0] is 0, so send stays low
  assign send = credits != '0 && req_valid[sel];
  assign flit = req_data[int'(sel)*20 +: 20];
  assign ftype = flit[19:18];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      rr_ptr <= rr_ptr_n;
    end
  end
  // stray body/tail in IDLE behaves as a single; stray head/single in LOCKED behaves as a body
  always_comb begin
    state_n = state;
    owner_n = owner;
    rr_ptr_n = rr_ptr;
    perr_set = 1'b0;
    if (send && state == IDLE) begin
      state_n = ftype == 2'b01 ? LOCKED : IDLE;
      owner_n = ftype == 2'b01 ? sel : owner;
      rr_ptr_n = ftype == 2'b01 ? rr_ptr : sel_inc;
      perr_set = !ftype[0];
    end else if (send) begin
      state_n = ftype == 2'b10 ? IDLE : LOCKED;
      rr_ptr_n = ftype == 2'b10 ? sel_inc : rr_ptr;
      perr_set = ftype[0];
    end
  end
  always_comb begin
    req_ready = send ? NREQ'(1) << sel : '0;
    grant = state == LOCKED ? NREQ'(1) << owner : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataout <= '0;
      out_valid <= 1'b0;
      credits <= CW'(CREDITS);
      proto_err <= 1'b0;
      credit_err <= 1'b0;
    end else begin
      out_valid <= send;
      dataout <= send ? flit : dataout;
      credits <= send && !ci ? credits - 1'b1 :
                 !send && ci && credits != CW'(CREDITS) ? credits + 1'b1 : credits;
      proto_err <= proto_err | perr_set;
      credit_err <= credit_err | (ci && !send && credits == CW'(CREDITS));
    end
  end
endmodule

// File: tb/tb_pe_inject_arbiter.sv
// tb_pe_inject_arbiter: scoreboard bench for pe_inject_arbiter
`timescale 1ns/1ps
module tb_pe_inject_arbiter;
  localparam int NREQ = 4;
  localparam int CREDITS = 7;
  localparam int CW = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ci = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*20-1:0] req_data = '0;
  logic [NREQ-1:0] req_ready, grant;
  logic [19:0] dataout;
  logic out_valid;
  logic [CW-1:0] credits;
  logic proto_err, credit_err;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [19:0] exp_q[$];
  int hs_q[$];
  logic [19:0] src_q[NREQ][$];
  pe_inject_arbiter #(.NREQ(NREQ), .CREDITS(CREDITS), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .ci(ci), .dataout(dataout), .out_valid(out_valid), .grant(grant), .credits(credits),
    .proto_err(proto_err), .credit_err(credit_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  // sources present queue heads on negedge, handshakes sampled just before posedge
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = src_q[i].size() > 0;
      req_data[20*i +: 20] = src_q[i].size() > 0 ? src_q[i][0] : 20'h0;
    end
    #3;
    if (!rst)
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && req_ready[i]) begin
          void'(src_q[i].pop_front());
          hs_q.push_back(cyc + 1);
        end
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_flit got=%0h want=none", dataout);
      end else chk("flit", dataout, exp_q.pop_front());
      if (hs_q.size() != 0) chk("latency", cyc, hs_q.pop_front());
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic pulse_ci();
    ci = 1'b1;
    step();
    ci = 1'b0;
  endtask
  task automatic refill();
    for (int n = 0; n < 10 && credits != CW'(CREDITS); n++) pulse_ci();
    chk("refill", credits, CREDITS);
  endtask
  task automatic drain(input string name);
    for (int n = 0; n < 60 && exp_q.size() != 0; n++) step();
    step();
    step();
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask
  task automatic push(input int s, input logic [19:0] f, input bit expect_out);
    src_q[s].push_back(f);
    if (expect_out) exp_q.push_back(f);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    step();
    chk("rst_credits", credits, 7);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_grant", grant, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_errs", {proto_err, credit_err}, 0);
    for (int i = 0; i < 3; i++) begin
      push(0, 20'hC0001, 1);
      push(2, 20'hC0002, 1);
    end
    drain("rr");
    chk("rr_credits", credits, 1);
    refill();
    push(1, 20'h40011, 1);
    push(1, 20'h00012, 1);
    push(1, 20'h00013, 1);
    push(1, 20'h80014, 1);
    exp_q.push_back(20'hC0031);
    for (int n = 0; n < 20 && grant != 4'b0010; n++) step();
    chk("lock_grant", grant, 4'b0010);
    src_q[3].push_back(20'hC0031);
    step();
    chk("lock_hold1", grant, 4'b0010);
    chk("lock_ready", req_ready, 4'b0010);
    step();
    chk("lock_hold2", grant, 4'b0010);
    drain("lock");
    chk("lock_credits", credits, 2);
    refill();
    for (int i = 0; i < 10; i++) push(0, 20'hC0100 + 20'(i), i < 7);
    drain("exh");
    chk("exh_credits", credits, 0);
    chk("exh_ready", req_ready, 0);
    chk("exh_out_valid", out_valid, 0);
    exp_q.push_back(20'hC0107);
    pulse_ci();
    chk("exh_ci", credits, 1);
    drain("exh1");
    chk("exh1_credits", credits, 0);
    exp_q.push_back(20'hC0108);
    exp_q.push_back(20'hC0109);
    pulse_ci();
    step();
    pulse_ci();
    drain("exh2");
    chk("exh2_credits", credits, 0);
    refill();
    for (int i = 0; i < 4; i++) push(0, 20'hC0200 + 20'(i), 1);
    drain("sim_pre");
    chk("sim_pre_credits", credits, 3);
    push(0, 20'hC0204, 1);
    ci = 1'b1;
    step();
    ci = 1'b0;
    chk("sim_credits", credits, 3);
    drain("sim");
    chk("sim_credit_err", credit_err, 0);
    refill();
    pulse_ci();
    chk("ci_full_credits", credits, 7);
    chk("ci_full_err", credit_err, 1);
    chk("ci_full_proto", proto_err, 0);
    push(1, 20'h00055, 1);
    drain("proto");
    chk("proto_err", proto_err, 1);
    chk("proto_grant", grant, 0);
    push(2, 20'h40066, 1);
    push(2, 20'h00067, 0);
    for (int n = 0; n < 20 && grant != 4'b0100; n++) step();
    chk("mid_lock", grant, 4'b0100);
    rst = 1'b1;
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_grant", grant, 0);
    chk("mid_credits", credits, 7);
    chk("mid_errs", {proto_err, credit_err}, 0);
    src_q[2].delete();
    step();
    rst = 1'b0;
    step();
    chk("post_out_valid", out_valid, 0);
    chk("post_ready", req_ready, 0);
    chk("post_grant", grant, 0);
    chk("post_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_inject_arbiter.md
Name: pe_inject_arbiter

Overview:
Injection-side scheduler for a processing element. It shares the PE's single NoC TX injection port between NREQ local traffic sources using packet-atomic round-robin arbitration. It enforces credit-based flow control against the downstream router buffer: credits are consumed per flit sent and returned one at a time on `ci`. It sits between the PE's flit generators and the router local input port.

Parameters:
NREQ, 4, number of requesting sources (2..8)
CREDITS, 7, downstream buffer depth; initial and maximum credit count
CW, 3, credit counter width; must satisfy 2^CW > CREDITS

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NREQ  per-source flit valid
req_data  input  NREQ*20  per-source flit; source i occupies bits [20*i+19:20*i]
req_ready  output  NREQ  per-source accept (combinational); transfer on valid&ready
ci  input  1  credit return pulse, one credit per cycle high
dataout  output  20  flit to router (registered)
out_valid  output  1  dataout valid, one cycle per flit
grant  output  NREQ  one-hot current owner while LOCKED, else 0
credits  output  CW  current credit count
proto_err  output  1  sticky: body/tail flit seen while not locked
credit_err  output  1  sticky: ci received with credits == CREDITS

Behaviour:
- Flit type field is bits [19:18]: 01 = head, 00 = body, 10 = tail, 11 = single (head+tail).
- Reset values (async on rst high): dataout = 0, out_valid = 0, grant = 0, credits = CREDITS, rr_ptr = 0, state = IDLE, proto_err = 0, credit_err = 0.
- States: IDLE and LOCKED(owner).
- IDLE selection: candidate = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NREQ. If credits > 0, only req_ready[candidate] = 1. All others are 0. No candidate means all 0.
- LOCKED selection: req_ready[owner] = req_valid[owner] & (credits > 0). All others are 0. grant = onehot(owner).
- credits == 0: all req_ready = 0 in both states. State and grant are held.
- Transfer on a cycle where the selected source has valid & ready:
  - Next edge: dataout <= that flit, out_valid <= 1.
  - Otherwise out_valid <= 0 and dataout holds its last value.
  - Latency is 1 cycle from handshake to out_valid.
  - At most one flit per cycle.
- IDLE transitions by transferred flit type:
  - head: go to LOCKED with owner = source.
  - single: stay in IDLE; rr_ptr <= (source+1) mod NREQ.
  - body or tail: treat as single; set proto_err.
- LOCKED transitions by transferred flit type:
  - body: stay locked.
  - tail: go to IDLE; rr_ptr <= (owner+1) mod NREQ.
  - head or single: accept it, stay locked (owner unchanged), set proto_err.
- Deassertion of req_valid while LOCKED does not release the lock. Other sources stall until the owner's tail is sent.
- Credit counter update per cycle:
  - send only: credits - 1.
  - ci only and credits < CREDITS: credits + 1.
  - send and ci together: unchanged.
  - ci with credits == CREDITS and no send: unchanged; set credit_err.
  - Never wraps.
- Send is gated by credits > 0 from the current count. A ci arriving in the same cycle does not enable a send at credits == 0; it becomes usable the next cycle.
- proto_err and credit_err clear only on rst.
- Reset mid-packet: lock is dropped, credits return to CREDITS, any in-flight out_valid is cleared immediately (asynchronous).

Test Plan:
- Reset: assert rst with all inputs idle, then release -> credits = 7, out_valid = 0, grant = 0, all req_ready = 0.
- Round-robin: sources 0 and 2 each hold a single flit (type 11, payloads 0xC0001/0xC0002) continuously -> out_valid flits alternate src0, src2, src0, ...; each appears one cycle after its handshake; credits decrement by 1 per flit.
- Packet lock: source 1 sends head/body/body/tail while source 3 is valid throughout -> the four flits are contiguous and grant = 0010 throughout; source 3 is first served immediately after the tail.
- Credit exhaustion: no ci, source 0 streams 10 single flits -> exactly 7 sent and credits = 0 with req_ready = 0. One ci pulse -> credits becomes 1, one more flit is sent the next cycle, and credits returns to 0.
- Simultaneous ci and send at credits = 3 -> credits stays 3. ci with credits = 7 -> credits stays 7 and credit_err = 1.
- Protocol and mid-reset: a body flit from idle -> accepted and proto_err = 1. Then head from source 2 followed by rst mid-packet -> grant = 0, credits = 7, both error flags = 0.
